// File: rtl/fetch_unit.sv
// Program-counter / fetch-control stage: IDLE/RUN/DONE sequencing, next-PC selection
// (sequential, relative, 64-entry jump LUT) and a saturating retired-instruction counter.
module fetch_unit #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             Jump,
  input  logic [1:0]       LUTSel,
  input  logic [3:0]       TargSel,
  input  logic             Ack,
  input  logic             CondFlag,
  input  logic [5:0]       RelOffset,
  input  logic             LutWrEn,
  input  logic [5:0]       LutWrAddr,
  input  logic [PC_W-1:0]  LutWrData,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  localparam int unsigned LUT_N = 64;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_running;
  logic             r_done;
  logic [PC_W-1:0]  r_lut [LUT_N];

  logic [PC_W-1:0]  w_lut_targ;
  logic [PC_W-1:0]  w_rel_targ;
  logic [PC_W-1:0]  w_pc_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_taken;

  assign w_lut_targ = r_lut[{LUTSel, TargSel}];
  // Signed cast sign-extends the 6-bit offset; the add wraps modulo 2^PC_W.
  assign w_rel_targ = r_pc + PC_W'($signed(RelOffset));
  assign w_taken    = BranchEn & CondFlag;
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_pc_next = r_pc + PC_W'(1);
    if (w_taken && Jump)
      w_pc_next = w_lut_targ;
    else if (w_taken)
      w_pc_next = w_rel_targ;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < LUT_N; i++) r_lut[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (LutWrEn && (r_state == ST_IDLE))
            r_lut[LutWrAddr] <= LutWrData;
          if (Start) begin
            r_state   <= ST_RUN;
            r_pc      <= StartAddr;
            r_cnt     <= '0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        ST_RUN: begin
          // Ack outranks BranchEn since the end-of-program encoding also decodes as a branch.
          if (!Stall) begin
            r_cnt <= w_cnt_inc;
            if (Ack) begin
              r_state   <= ST_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_pc <= w_pc_next;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign ProgCtr   = r_pc;
  assign Running   = r_running;
  assign Done      = r_done;
  assign InstCount = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: expected PCs are queued as each cycle is driven and
// popped for comparison one time unit after the following rising edge.
module tb_fetch_unit;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic       br;
    logic       jmp;
    logic       cond;
    logic       ack;
    logic       stall;
    logic [1:0] sel;
    logic [3:0] targ;
    logic [5:0] off;
  } stim_t;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             Stall, BranchEn, Jump, Ack, CondFlag, LutWrEn;
  logic [1:0]       LUTSel;
  logic [3:0]       TargSel;
  logic [5:0]       RelOffset, LutWrAddr;
  logic [PC_W-1:0]  LutWrData;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running, Done;
  logic [CNT_W-1:0] InstCount;

  int n_cmp = 0;
  int n_err = 0;
  logic [PC_W-1:0] exp_q [$];

  fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
    .BranchEn(BranchEn), .Jump(Jump), .LUTSel(LUTSel), .TargSel(TargSel), .Ack(Ack),
    .CondFlag(CondFlag), .RelOffset(RelOffset), .LutWrEn(LutWrEn), .LutWrAddr(LutWrAddr),
    .LutWrData(LutWrData), .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
    .InstCount(InstCount)
  );

  always #5 Clk = ~Clk;

  function automatic stim_t plain();
    return '0;
  endfunction
  function automatic stim_t rel(input logic cond, input logic [5:0] off);
    stim_t s = '0;
    s.br = 1'b1; s.cond = cond; s.off = off;
    return s;
  endfunction
  function automatic stim_t lut(input logic [1:0] sel, input logic [3:0] targ);
    stim_t s = '0;
    s.br = 1'b1; s.jmp = 1'b1; s.cond = 1'b1; s.sel = sel; s.targ = targ;
    return s;
  endfunction
  function automatic stim_t ackb(input logic stall);
    stim_t s = '0;
    s.ack = 1'b1; s.br = 1'b1; s.jmp = 1'b1; s.cond = 1'b1; s.stall = stall;
    return s;
  endfunction

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input stim_t s);
    BranchEn = s.br; Jump = s.jmp; CondFlag = s.cond; Ack = s.ack; Stall = s.stall;
    LUTSel = s.sel; TargSel = s.targ; RelOffset = s.off;
  endtask

  task automatic launch(input logic [PC_W-1:0] a);
    drive(plain());
    Start = 1'b1; StartAddr = a;
    cycle();
    Start = 1'b0;
  endtask

  task automatic lut_write(input logic [5:0] a, input logic [PC_W-1:0] d);
    LutWrEn = 1'b1; LutWrAddr = a; LutWrData = d;
    cycle();
    LutWrEn = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    cycle(); cycle();
    n_cmp++; if (ProgCtr !== '0)  begin n_err++; $display("FAIL reset_pc: got %0h expected 0", ProgCtr); end
    n_cmp++; if (Running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b expected 0", Running); end
    n_cmp++; if (Done !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %b expected 0", Done); end
    n_cmp++; if (InstCount !== '0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", InstCount); end
    Reset = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    logic [PC_W-1:0] e;
    lut_write(6'h10, 10'h123);
    launch(10'd5);
    n_cmp++; if (ProgCtr !== 10'd5 || Running !== 1'b1)
      begin n_err++; $display("FAIL midrun_launch: got pc=%0h run=%b expected pc=5 run=1", ProgCtr, Running); end
    for (int i = 0; i < 3; i++) begin
      drive(plain()); exp_q.push_back(10'(6 + i)); cycle();
      e = exp_q.pop_front();
      n_cmp++; if (ProgCtr !== e) begin n_err++; $display("FAIL midrun_seq: got %0h expected %0h", ProgCtr, e); end
    end
    Reset = 1'b0;
    #1;
    n_cmp++; if (ProgCtr !== '0 || Running !== 1'b0 || InstCount !== '0 || Done !== 1'b0)
      begin n_err++; $display("FAIL midrun_async: got pc=%0h run=%b cnt=%0d done=%b expected 0/0/0/0", ProgCtr, Running, InstCount, Done); end
    cycle();
    n_cmp++; if (ProgCtr !== '0) begin n_err++; $display("FAIL midrun_hold: got %0h expected 0", ProgCtr); end
    Reset = 1'b1;
    launch(10'd50);
    drive(lut(2'd1, 4'd0)); exp_q.push_back(10'h000); cycle();
    e = exp_q.pop_front();
    n_cmp++; if (ProgCtr !== e) begin n_err++; $display("FAIL midrun_lut_cleared: got %0h expected %0h", ProgCtr, e); end
  endtask

  task automatic test_lut_jump();
    stim_t tab [6];
    logic [PC_W-1:0] ex [6];
    logic [PC_W-1:0] e;
    do_reset();
    lut_write(6'h23, 10'h3FE);
    lut_write(6'h05, 10'h155);
    lut_write(6'h3F, 10'h0AA);
    launch(10'd0);
    tab[0] = lut(2'd2, 4'd3); ex[0] = 10'h3FE;
    tab[1] = plain();         ex[1] = 10'h3FF;
    tab[2] = plain();         ex[2] = 10'h000;
    tab[3] = plain();         ex[3] = 10'h001;
    tab[4] = lut(2'd0, 4'd5); ex[4] = 10'h155;
    tab[5] = ackb(1'b0);      ex[5] = 10'h155;
    for (int i = 0; i < 6; i++) begin
      drive(tab[i]);
      LutWrEn = (i == 3); LutWrAddr = 6'h05; LutWrData = 10'h0F0;
      exp_q.push_back(ex[i]); cycle();
      e = exp_q.pop_front();
      n_cmp++; if (ProgCtr !== e) begin n_err++; $display("FAIL lut_jump[%0d]: got %0h expected %0h", i, ProgCtr, e); end
    end
    LutWrEn = 1'b0;
    n_cmp++; if (Done !== 1'b1 || Running !== 1'b0 || InstCount !== 4'd6)
      begin n_err++; $display("FAIL lut_done: got done=%b run=%b cnt=%0d expected 1/0/6", Done, Running, InstCount); end
  endtask

  task automatic test_relative();
    stim_t tab [9];
    logic [PC_W-1:0] ex [9];
    logic [PC_W-1:0] e;
    launch(10'd10);
    tab[0] = rel(1'b1, 6'h3D);  ex[0] = 10'd7;
    tab[1] = rel(1'b1, 6'd31);  ex[1] = 10'd38;
    tab[2] = rel(1'b1, 6'h24);  ex[2] = 10'd10;
    tab[3] = rel(1'b0, 6'h3D);  ex[3] = 10'd11;
    tab[4] = plain(); tab[4].cond = 1'b1; tab[4].off = 6'd5; ex[4] = 10'd12;
    tab[5] = ackb(1'b0);        ex[5] = 10'd12;
    tab[6] = plain(); tab[6].cond = 1'b1; ex[6] = 10'd12;
    tab[7] = rel(1'b1, 6'h20);  ex[7] = 10'h3E2;
    tab[8] = rel(1'b1, 6'h00);  ex[8] = 10'h3E2;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) launch(10'd2);
      drive(tab[i]); exp_q.push_back(ex[i]); cycle();
      e = exp_q.pop_front();
      n_cmp++; if (ProgCtr !== e) begin n_err++; $display("FAIL relative[%0d]: got %0h expected %0h", i, ProgCtr, e); end
    end
    n_cmp++; if (Running !== 1'b1 || InstCount !== 4'd2)
      begin n_err++; $display("FAIL relative_count: got run=%b cnt=%0d expected 1/2", Running, InstCount); end
  endtask

  task automatic test_ack_stall();
    do_reset();
    launch(10'd20);
    drive(ackb(1'b1)); cycle();
    n_cmp++; if (ProgCtr !== 10'd20 || Running !== 1'b1 || Done !== 1'b0 || InstCount !== 4'd0)
      begin n_err++; $display("FAIL ack_stalled: got pc=%0h run=%b done=%b cnt=%0d expected 20/1/0/0", ProgCtr, Running, Done, InstCount); end
    drive(ackb(1'b0)); cycle();
    n_cmp++; if (ProgCtr !== 10'd20 || Running !== 1'b0 || Done !== 1'b1 || InstCount !== 4'd1)
      begin n_err++; $display("FAIL ack_taken: got pc=%0h run=%b done=%b cnt=%0d expected 20/0/1/1", ProgCtr, Running, Done, InstCount); end
    drive(plain()); cycle();
    n_cmp++; if (ProgCtr !== 10'd20 || Done !== 1'b1)
      begin n_err++; $display("FAIL ack_hold: got pc=%0h done=%b expected 20/1", ProgCtr, Done); end
  endtask

  task automatic test_counter_relaunch();
    logic [PC_W-1:0] e;
    logic [PC_W-1:0] pc;
    do_reset();
    lut_write(6'h3F, 10'h0AA);
    launch(10'd100);
    pc = 10'd100;
    for (int i = 0; i < 9; i++) begin
      drive(plain());
      Stall = (i == 3 || i == 6);
      if (!Stall) pc = pc + 10'd1;
      exp_q.push_back(pc); cycle();
      e = exp_q.pop_front();
      n_cmp++; if (ProgCtr !== e) begin n_err++; $display("FAIL count_seq[%0d]: got %0h expected %0h", i, ProgCtr, e); end
    end
    drive(ackb(1'b0)); cycle();
    drive(plain());
    LutWrEn = 1'b1; LutWrAddr = 6'h3F; LutWrData = 10'h111;
    cycle();
    LutWrEn = 1'b0;
    n_cmp++; if (InstCount !== 4'd8 || Done !== 1'b1 || ProgCtr !== 10'd107)
      begin n_err++; $display("FAIL count_done: got cnt=%0d done=%b pc=%0h expected 8/1/107", InstCount, Done, ProgCtr); end
    launch(10'd40);
    n_cmp++; if (ProgCtr !== 10'd40 || Running !== 1'b1 || Done !== 1'b0 || InstCount !== 4'd0)
      begin n_err++; $display("FAIL relaunch: got pc=%0h run=%b done=%b cnt=%0d expected 40/1/0/0", ProgCtr, Running, Done, InstCount); end
    drive(lut(2'd3, 4'd15)); exp_q.push_back(10'h0AA); cycle();
    e = exp_q.pop_front();
    n_cmp++; if (ProgCtr !== e) begin n_err++; $display("FAIL relaunch_lut: got %0h expected %0h", ProgCtr, e); end
  endtask

  task automatic test_saturate();
    logic [PC_W-1:0] e;
    do_reset();
    launch(10'h3F8);
    for (int i = 0; i < 17; i++) begin
      drive(plain()); exp_q.push_back(10'(10'h3F9 + i)); cycle();
      e = exp_q.pop_front();
      n_cmp++; if (ProgCtr !== e) begin n_err++; $display("FAIL sat_seq[%0d]: got %0h expected %0h", i, ProgCtr, e); end
    end
    n_cmp++; if (InstCount !== 4'hF) begin n_err++; $display("FAIL sat_count: got %0d expected 15", InstCount); end
    drive(ackb(1'b0)); cycle();
    n_cmp++; if (InstCount !== 4'hF || Done !== 1'b1)
      begin n_err++; $display("FAIL sat_ack: got cnt=%0d done=%b expected 15/1", InstCount, Done); end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; StartAddr = '0; LutWrEn = 1'b0; LutWrAddr = '0; LutWrData = '0;
    drive(plain());
    test_reset();
    test_reset_mid_run();
    test_lut_jump();
    test_relative();
    test_ack_stall();
    test_counter_relaunch();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-control stage that sits directly upstream of the control decoder. It drives the instruction ROM address and, each cycle, consumes the decoder's branch outputs (`BranchEn`, `Jump`, `LUTSel`, `TargSel`, `Ack`) plus a condition flag to choose the next PC. The next PC is one of: sequential, relative, or a target from an internal 64-entry jump LUT. The block also owns the program start/done handshake with the testbench and counts retired instructions.

## Interface
- `PC_W`, 10, program counter / ROM address width (4..16)
- `CNT_W`, 16, retired-instruction counter width
- `Clk`  in  1  sole clock, all state on rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  level; sampled high in IDLE or DONE launches a program
- `StartAddr`  in  PC_W  PC loaded on launch
- `Stall`  in  1  freezes PC and counter while in RUN
- `BranchEn`  in  1  from decoder: current instruction is a branch
- `Jump`  in  1  from decoder: 1 = LUT target, 0 = relative
- `LUTSel`  in  2  from decoder: LUT bank
- `TargSel`  in  4  from decoder: LUT entry within bank
- `Ack`  in  1  from decoder: current instruction is program end
- `CondFlag`  in  1  branch condition (R0 LSB / ALU flag); taken when 1
- `RelOffset`  in  6  signed relative offset for `Jump`=0 branches
- `LutWrEn`  in  1  LUT write strobe
- `LutWrAddr`  in  6  LUT write index {bank, entry}
- `LutWrData`  in  PC_W  LUT write value
- `ProgCtr`  out  PC_W  instruction ROM address (registered)
- `Running`  out  1  high in RUN
- `Done`  out  1  high in DONE
- `InstCount`  out  CNT_W  instructions retired since last launch

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: `Start`=1 → RUN; `ProgCtr`←`StartAddr`; `InstCount`←0.
- IDLE: `LutWrEn`=1 → LUT[`LutWrAddr`]←`LutWrData`. LUT writes in RUN or DONE are ignored.
- RUN, `Stall`=1: hold all state. `Ack`, branch inputs and `Start` are ignored that cycle.
- RUN, `Stall`=0, evaluated in priority order:
  1. `Ack`=1 → DONE; PC holds (points at the Ack instruction); `InstCount`+1. Ack has priority over `BranchEn`, because the Ack encoding also decodes as a branch.
  2. `BranchEn`&`CondFlag`&`Jump` → PC←LUT[{`LUTSel`,`TargSel`}].
  3. `BranchEn`&`CondFlag`&!`Jump` → PC←PC+sext(`RelOffset`), modulo 2^PC_W.
  4. Otherwise (including a not-taken branch) → PC←PC+1, modulo 2^PC_W.
- In cases 2–4, `InstCount` increments, saturating at all-ones.
- DONE: PC and `InstCount` hold. `Start`=1 → RUN with the same launch actions as from IDLE. The LUT is preserved.
- `Start` is ignored in RUN.
- LUT contents are cleared to 0 by reset only.
- Arithmetic:
  - Relative target is (PC + sign-extended 6-bit offset) truncated to PC_W, so offset −32..+31.
  - PC+1 at all-ones wraps to 0.
  - Offset 0 on a taken branch holds PC, which forms a tight loop.

## Timing
- Reset asserted (async, any time, including mid-RUN), with all values holding until `Reset` deasserts:
  - `ProgCtr`=0, `Running`=0, `Done`=0, `InstCount`=0
  - state=IDLE, all LUT entries 0
- All outputs are registered; no combinational path from inputs to outputs.
- Instruction ROM and decoder are combinational from `ProgCtr`. Decoder inputs are therefore valid in the same cycle `ProgCtr` is presented, and the next PC is taken at the following edge.
- Latency:
  - `Start` high at edge N → `Running`=1 and `ProgCtr`=`StartAddr` after edge N.
  - `Ack` seen at edge M → `Done`=1, `Running`=0 after edge M.
- A LUT write at edge N is visible to a jump executed in any later RUN cycle. Writes cannot collide with reads, since writes are honoured only in IDLE.
- Exactly one instruction retires per non-stalled RUN cycle.

## Test plan
- **Reset mid-run.** Reset, launch `StartAddr`=5, run 3 non-branch cycles, then assert `Reset` low mid-cycle → `ProgCtr` goes 5,6,7,8, then immediately 0. `Running`=0, `InstCount`=0. A LUT entry written before launch reads back 0 on the next jump.
- **LUT jump and sequential wrap.** In IDLE write LUT[0x23]=0x3FE. Launch at 0. Present `BranchEn`=1, `Jump`=1, `LUTSel`=2, `TargSel`=3, `CondFlag`=1 → `ProgCtr`=0x3FE. Then two plain cycles → 0x3FF, then 0x000.
- **Relative branches.** At PC=10:
  - `RelOffset`=−3 taken → 7.
  - `RelOffset`=+31 taken → 38.
  - `CondFlag`=0 → 11.
  - At PC=2, `RelOffset`=−32 → 0x3E2 (wrap).
- **Ack priority with stall.** `Ack`=1 with `BranchEn`=1, `Jump`=1, `CondFlag`=1 at PC=20 → `Done`=1, `ProgCtr` stays 20. The same inputs with `Stall`=1 → stays in RUN, PC 20, no count change.
- **Counter and relaunch.** Launch, retire 7 instructions with 2 stall cycles interleaved, then Ack → `InstCount`=8 held in DONE. `Start`=1 with `StartAddr`=40 → RUN, PC 40, `InstCount`=0, earlier LUT entries intact.
- **Ignored LUT writes.** `LutWrEn` during RUN to entry 0x05 → LUT[0x05] unchanged, as checked by a later jump.
